// File: rtl/mem_port_b_reader_if.sv
// Handshake bundle for the port-B read-out engine: control, memory port B
// and the streaming output. master = the reader, slave = its environment.
interface mem_port_b_reader_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 24
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] address_b;
  logic [DATA_WIDTH-1:0] read_data_b;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, base_addr, length, abort, read_data_b, out_ready,
    output address_b, out_data, out_valid, busy, done
  );

  modport slave (
    output start, base_addr, length, abort, read_data_b, out_ready,
    input  address_b, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/mem_port_b_reader.sv
// Port-B sequential read-out engine: streams a contiguous block of memory
// words to a valid/ready consumer with at most two words buffered or in flight.
module mem_port_b_reader #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 24
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mem_port_b_reader_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;

  state_t                r_state, w_state_nxt;
  logic                  r_done, w_done_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_issue_cnt;
  logic [ADDR_WIDTH:0]   r_deliv_cnt;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic                  r_rd_ptr, r_wr_ptr;
  logic [1:0]            r_cnt;

  logic                  w_active, w_abort, w_launch;
  logic                  w_valid, w_pop, w_push, w_issue;
  logic [2:0]            w_occ;

  assign w_active = (r_state != S_IDLE);
  assign w_abort  = w_active && bus.abort;
  assign w_launch = (r_state == S_IDLE) && bus.start && (bus.length != '0);
  assign w_valid  = (r_cnt != 2'd0);
  assign w_pop    = w_valid && bus.out_ready;
  assign w_push   = r_inflight && w_active && !bus.abort;

  // Credit check counts a same-cycle pop as a free slot, so a full-rate
  // stream keeps one read in flight and one word at the head every cycle.
  assign w_occ   = 3'(r_cnt) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue = (r_state == S_RUN) && !bus.abort &&
                   (r_issue_cnt != '0) && (w_occ < 3'd2);

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) w_state_nxt = S_RUN;
          else                  w_done_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_issue && (r_issue_cnt == (ADDR_WIDTH+1)'(1))) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.abort || (w_pop && (r_deliv_cnt == (ADDR_WIDTH+1)'(1)))) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_deliv_cnt <= '0;
      r_inflight  <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_cnt       <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_launch) begin
        r_addr      <= bus.base_addr;
        r_issue_cnt <= bus.length;
        r_deliv_cnt <= bus.length;
      end else begin
        if (w_issue) begin
          r_addr      <= r_addr + ADDR_WIDTH'(1);
          r_issue_cnt <= r_issue_cnt - (ADDR_WIDTH+1)'(1);
        end
        if (w_pop && !w_abort) r_deliv_cnt <= r_deliv_cnt - (ADDR_WIDTH+1)'(1);
      end

      // Memory returns data one cycle after the address is sampled.
      r_inflight <= w_issue;

      if (w_abort) begin
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
        r_cnt    <= 2'd0;
      end else begin
        if (w_push) begin
          r_fifo[r_wr_ptr] <= bus.read_data_b;
          r_wr_ptr         <= ~r_wr_ptr;
        end
        if (w_pop) r_rd_ptr <= ~r_rd_ptr;
        r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
      end
    end
  end

  assign bus.address_b = r_addr;
  assign bus.out_data  = r_fifo[r_rd_ptr];
  assign bus.out_valid = w_valid;
  assign bus.busy      = w_active;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_mem_port_b_reader.sv
// Randomized bench for mem_port_b_reader: a flat memory model feeds port B and
// each streamed word is checked against the expected block read.
module tb_mem_port_b_reader;
  localparam int AW = 17;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_b_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  mem_port_b_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) bus.read_data_b <= mem[bus.address_b];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] obs_q [$];
  logic [AW-1:0] addr_q [$];
  int done_cnt, done_cyc, hold_viol, max_out, first_cyc, last_cyc;
  int post_chg, post_valid, valid_seen, busy_seen;
  bit timed_out;
  logic ps_valid, ps_busy, ps_done;
  logic [AW-1:0] ps_addr, stop_addr;
  logic [DW-1:0] ps_data;

  function automatic void build_exp(input logic [AW-1:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mem[AW'(base + i)]);
  endfunction

  // Drives one transfer and records what the consumer side sees.
  // rmode: 0 always ready, 1 ready pattern 1,0,0, 2 random ready.
  // stop_kind: 0 none, 1 abort, 2 reset, applied once stop_at words are in.
  task automatic xfer(input logic [AW-1:0] base, input logic [AW:0] len,
                      input int rmode, input int stop_kind, input int stop_at,
                      input int extra_start);
    int c, issued, delivered, end_cyc, stop_cyc;
    bit stopped, hold_pend, rdy;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] hold_data;
    obs_q.delete(); addr_q.delete();
    done_cnt = 0; done_cyc = -1; hold_viol = 0; max_out = 0;
    first_cyc = -1; last_cyc = -1; post_chg = 0; post_valid = 0;
    valid_seen = 0; busy_seen = 0; timed_out = 0;
    issued = 0; delivered = 0; end_cyc = -1; stop_cyc = -1;
    stopped = 0; hold_pend = 0; hold_data = '0;
    bus.start = 1'b1; bus.base_addr = base; bus.length = len; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    prev_addr = bus.address_b;
    addr_q.push_back(bus.address_b);
    c = 0;
    forever begin
      if (c > 0 && bus.address_b !== prev_addr) begin
        if (stopped) post_chg++;
        else begin addr_q.push_back(bus.address_b); issued++; end
      end
      prev_addr = bus.address_b;
      if (hold_pend && !(bus.out_valid === 1'b1 && bus.out_data === hold_data)) hold_viol++;
      if (bus.done === 1'b1) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (bus.out_valid === 1'b1) begin valid_seen++; if (stopped) post_valid++; end
      if (bus.busy === 1'b1) busy_seen++;
      if (!stopped && issued - delivered > max_out) max_out = issued - delivered;
      if (stopped && c == stop_cyc + 1) begin
        ps_valid = bus.out_valid; ps_busy = bus.busy; ps_done = bus.done;
        ps_addr = bus.address_b; ps_data = bus.out_data;
      end
      if (end_cyc < 0 && (bus.done === 1'b1 || (stopped && c == stop_cyc + 1))) end_cyc = c + 3;
      if (c == end_cyc) break;
      if (c >= 400) begin timed_out = 1; break; end

      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.abort = 1'b0; rst_n = 1'b1;
      bus.start = (c == extra_start);
      if (c == extra_start) begin bus.base_addr = AW'(base + 7); bus.length = (AW+1)'(5); end
      if (!stopped && stop_kind != 0 && delivered == stop_at) begin
        rdy = 1'b0; stopped = 1; stop_cyc = c; stop_addr = bus.address_b;
        if (stop_kind == 1) bus.abort = 1'b1; else rst_n = 1'b0;
      end
      bus.out_ready = rdy;
      if (bus.out_valid === 1'b1 && rdy) begin
        obs_q.push_back(bus.out_data); delivered++;
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
      end
      hold_pend = (bus.out_valid === 1'b1) && !rdy && !stopped;
      hold_data = bus.out_data;
      @(posedge clk); #1;
      c++;
    end
    bus.out_ready = 1'b0; bus.abort = 1'b0; bus.start = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.start = 1'($urandom); bus.abort = 1'($urandom); bus.out_ready = 1'($urandom);
      bus.base_addr = AW'($urandom); bus.length = (AW+1)'($urandom);
      @(posedge clk); #1;
    end
    checks++;
    if ({bus.address_b, bus.out_data, bus.out_valid, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0h data=%0h valid=%b busy=%b done=%b, expected all 0",
               bus.address_b, bus.out_data, bus.out_valid, bus.busy, bus.done);
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b valid=%b, expected 0 0 0", bus.busy, bus.done, bus.out_valid);
    end
  endtask

  task automatic test_full_rate();
    int bad;
    build_exp(AW'('h10), 4);
    xfer(AW'('h10), (AW+1)'(4), 0, 0, 0, -1);
    bad = 0;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || obs_q.size() != 4) begin
      errors++; $display("FAIL full_rate_data: got %0d words with %0d wrong, expected 4 correct", obs_q.size(), bad);
    end
    checks++;
    if (first_cyc != 2 || last_cyc != 5) begin
      errors++; $display("FAIL full_rate_timing: got first=%0d last=%0d, expected 2 and 5", first_cyc, last_cyc);
    end
    checks++;
    if (done_cyc != 6 || done_cnt != 1 || timed_out) begin
      errors++; $display("FAIL full_rate_done: got cycle=%0d count=%0d, expected cycle 6 count 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    build_exp(AW'('h10), 4);
    xfer(AW'('h10), (AW+1)'(4), 1, 0, 0, -1);
    bad = 0;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || obs_q.size() != 4) begin
      errors++; $display("FAIL bp_data: got %0d words with %0d wrong, expected 4 correct", obs_q.size(), bad);
    end
    checks++;
    if (hold_viol != 0) begin
      errors++; $display("FAIL bp_hold: got %0d unstable stalled cycles, expected 0", hold_viol);
    end
    checks++;
    if (max_out > 2) begin
      errors++; $display("FAIL bp_outstanding: got max %0d outstanding, expected at most 2", max_out);
    end
    checks++;
    if (done_cnt != 1 || timed_out) begin
      errors++; $display("FAIL bp_done: got %0d done pulses, expected 1", done_cnt);
    end
  endtask

  task automatic test_wrap();
    int bad;
    logic [AW-1:0] ea;
    build_exp(AW'('h1FFFE), 4);
    xfer(AW'('h1FFFE), (AW+1)'(4), 0, 0, 0, -1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      ea = AW'('h1FFFE + i);
      if (i >= addr_q.size() || addr_q[i] !== ea) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wrap_addr: got %0d wrong addresses of %0d seen, expected 1fffe 1ffff 0 1", bad, addr_q.size());
    end
    bad = 0;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || obs_q.size() != 4) begin
      errors++; $display("FAIL wrap_data: got %0d words with %0d wrong, expected 4 correct", obs_q.size(), bad);
    end
  endtask

  task automatic test_zero_and_ignored();
    logic [AW-1:0] pre_addr;
    int bad;
    logic [AW-1:0] b;
    pre_addr = bus.address_b;
    xfer(AW'('h555), (AW+1)'(0), 0, 0, 0, -1);
    checks++;
    if (done_cyc != 0 || done_cnt != 1) begin
      errors++; $display("FAIL zero_done: got cycle=%0d count=%0d, expected cycle 0 count 1", done_cyc, done_cnt);
    end
    checks++;
    if (addr_q.size() != 1 || addr_q[0] !== pre_addr || valid_seen != 0 || busy_seen != 0) begin
      errors++; $display("FAIL zero_quiet: got addrs=%0d addr=%0h valid=%0d busy=%0d, expected 1 %0h 0 0",
                         addr_q.size(), addr_q[0], valid_seen, busy_seen, pre_addr);
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL idle_abort: got done=%b busy=%b, expected 0 0", bus.done, bus.busy);
    end
    b = AW'($urandom);
    build_exp(b, 3);
    xfer(b, (AW+1)'(3), 0, 0, 0, 1);
    bad = 0;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || obs_q.size() != 3 || done_cyc != 5 || done_cnt != 1) begin
      errors++; $display("FAIL ignored_start: got %0d words %0d wrong done_cyc=%0d count=%0d, expected 3 0 5 1",
                         obs_q.size(), bad, done_cyc, done_cnt);
    end
  endtask

  task automatic test_abort_reset();
    int bad;
    logic [AW-1:0] b;
    b = AW'($urandom);
    build_exp(b, 8);
    xfer(b, (AW+1)'(8), 0, 1, 2, -1);
    bad = 0;
    for (int i = 0; i < 2; i++) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || obs_q.size() != 2) begin
      errors++; $display("FAIL abort_words: got %0d words %0d wrong, expected 2 correct", obs_q.size(), bad);
    end
    checks++;
    if (ps_addr !== stop_addr || post_chg != 0) begin
      errors++; $display("FAIL abort_addr: got addr=%0h changes=%0d, expected %0h 0", ps_addr, post_chg, stop_addr);
    end
    checks++;
    if (ps_valid !== 1'b0 || post_valid != 0 || ps_busy !== 1'b0 || ps_done !== 1'b1 || done_cnt != 1) begin
      errors++; $display("FAIL abort_state: got valid=%b busy=%b done=%b pulses=%0d, expected 0 0 1 1",
                         ps_valid, ps_busy, ps_done, done_cnt);
    end
    b = AW'($urandom);
    xfer(b, (AW+1)'(8), 0, 2, 2, -1);
    checks++;
    if ({ps_addr, ps_data, ps_valid, ps_busy, ps_done} !== '0 || done_cnt != 0 || post_valid != 0) begin
      errors++; $display("FAIL reset_mid: got addr=%0h data=%0h valid=%b busy=%b done=%b pulses=%0d, expected all 0",
                         ps_addr, ps_data, ps_valid, ps_busy, ps_done, done_cnt);
    end
  endtask

  task automatic test_random();
    int bad, n;
    logic [AW-1:0] b;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 10);
      b = (t % 2 == 0) ? AW'($urandom) : AW'((1 << AW) - $urandom_range(1, 6));
      build_exp(b, n);
      xfer(b, (AW+1)'(n), 2, 0, 0, -1);
      bad = 0;
      foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0 || obs_q.size() != n) begin
        errors++; $display("FAIL random_data[%0d]: got %0d words %0d wrong, expected %0d correct", t, obs_q.size(), bad, n);
      end
      checks++;
      if (done_cnt != 1 || hold_viol != 0 || max_out > 2 || timed_out) begin
        errors++; $display("FAIL random_proto[%0d]: got done=%0d hold=%0d max_out=%0d timeout=%0d, expected 1 0 <=2 0",
                           t, done_cnt, hold_viol, max_out, timed_out);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);
    for (int a = 0; a < 4; a++) mem['h10 + a] = DW'('hA00001 + a);
    bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
    bus.base_addr = '0; bus.length = '0;
    @(posedge clk); #1;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_wrap();
    test_zero_and_ignored();
    test_abort_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end
endmodule
